// File: rtl/mips_ucode_pkg.sv
// rtl/mips_ucode_pkg.sv - shared microword types, opcode constants and dispatch tables
package mips_ucode_pkg;

    localparam int UCODE_UPC_W = 5;
    localparam int UCODE_CW_W  = 16;

    // Microword layout: {ctrl, seq, target}
    localparam int MW_TARGET_LSB = 0;
    localparam int MW_SEQ_LSB    = 5;
    localparam int MW_CTRL_LSB   = 8;
    localparam int MW_W          = 24;

    localparam logic [UCODE_UPC_W-1:0] ILLEGAL_UPC = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [2:0] {
        SEQ_FETCH = 3'b000,
        SEQ_NEXT  = 3'b001,
        SEQ_DISP1 = 3'b010,
        SEQ_DISP2 = 3'b011,
        SEQ_JUMP  = 3'b100,
        SEQ_BRZ   = 3'b101,
        SEQ_WAIT  = 3'b110,
        SEQ_HALT  = 3'b111
    } seq_t;

    typedef struct packed {
        logic [UCODE_CW_W-1:0]  ctrl;
        seq_t                   seq;
        logic [UCODE_UPC_W-1:0] target;
    } microword_t;

    // Decode-stage dispatch; unmapped opcodes land on the HALT word at ILLEGAL_UPC
    function automatic logic [UCODE_UPC_W-1:0] disp1(input logic [5:0] op);
        case (op)
            OP_RTYPE: disp1 = 5'd6;
            OP_LW:    disp1 = 5'd2;
            OP_SW:    disp1 = 5'd2;
            OP_BEQ:   disp1 = 5'd8;
            OP_J:     disp1 = 5'd9;
            default:  disp1 = ILLEGAL_UPC;
        endcase
    endfunction

    // Memory-address-stage dispatch: splits loads from stores
    function automatic logic [UCODE_UPC_W-1:0] disp2(input logic [5:0] op);
        case (op)
            OP_LW:   disp2 = 5'd3;
            OP_SW:   disp2 = 5'd5;
            default: disp2 = ILLEGAL_UPC;
        endcase
    endfunction

endpackage

// File: rtl/ucode_rom.sv
// rtl/ucode_rom.sv - 32-entry combinational control store
module ucode_rom
    import mips_ucode_pkg::*;
(
    input  logic [UCODE_UPC_W-1:0] addr,
    output microword_t             uword
);

    // Microprogram image; unused slots simply return to fetch
    always_comb begin
        uword = '{ctrl: 16'h0000, seq: SEQ_FETCH, target: 5'd0};
        case (addr)
            5'd0:  uword = '{ctrl: 16'h9410, seq: SEQ_NEXT,  target: 5'd0};
            5'd1:  uword = '{ctrl: 16'h0018, seq: SEQ_DISP1, target: 5'd0};
            5'd2:  uword = '{ctrl: 16'h0014, seq: SEQ_DISP2, target: 5'd0};
            5'd3:  uword = '{ctrl: 16'h0300, seq: SEQ_NEXT,  target: 5'd0};
            5'd4:  uword = '{ctrl: 16'h0300, seq: SEQ_WAIT,  target: 5'd0};
            5'd5:  uword = '{ctrl: 16'h4A00, seq: SEQ_FETCH, target: 5'd0};
            5'd6:  uword = '{ctrl: 16'h0044, seq: SEQ_NEXT,  target: 5'd0};
            5'd7:  uword = '{ctrl: 16'h0C00, seq: SEQ_FETCH, target: 5'd0};
            5'd8:  uword = '{ctrl: 16'h20A4, seq: SEQ_BRZ,   target: 5'd12};
            5'd9:  uword = '{ctrl: 16'h0081, seq: SEQ_JUMP,  target: 5'd30};
            5'd12: uword = '{ctrl: 16'h0002, seq: SEQ_FETCH, target: 5'd0};
            5'd30: uword = '{ctrl: 16'h8000, seq: SEQ_NEXT,  target: 5'd0};
            5'd31: uword = '{ctrl: 16'h0000, seq: SEQ_HALT,  target: 5'd0};
            default: ;
        endcase
    end

endmodule

// File: rtl/microseq_ctrl.sv
// rtl/microseq_ctrl.sv - micro-PC sequencer for the microprogrammed MIPS control unit
module microseq_ctrl
    import mips_ucode_pkg::*;
#(
    parameter int UPC_W    = 5,
    parameter int CW_W     = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             cond_zero,
    input  logic             mem_ready,
    input  logic             stall,
    output logic [UPC_W-1:0] upc,
    output logic [CW_W-1:0]  ctrl_word,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic             halted
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    microword_t             uword;
    logic [WCNT_W-1:0]      wait_cnt;
    logic [UPC_W-1:0]       upc_inc;
    logic [UPC_W-1:0]       d1_upc;
    logic [UPC_W-1:0]       d2_upc;

    ucode_rom u_rom (
        .addr  (upc),
        .uword (uword)
    );

    assign ctrl_word = uword.ctrl;
    assign upc_inc   = upc + UPC_W'(1);
    assign d1_upc    = disp1(opcode);
    assign d2_upc    = disp2(opcode);

    // Next-address resolution; halted and stall freeze everything and suppress pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc         <= '0;
            wait_cnt    <= '0;
            instr_done  <= 1'b0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_done  <= 1'b0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
            if (!halted && !stall) begin
                case (uword.seq)
                    SEQ_FETCH: begin
                        upc        <= '0;
                        instr_done <= 1'b1;
                    end
                    SEQ_NEXT: upc <= upc_inc;
                    SEQ_DISP1: begin
                        upc        <= d1_upc;
                        illegal_op <= (d1_upc == ILLEGAL_UPC);
                    end
                    SEQ_DISP2: begin
                        upc        <= d2_upc;
                        illegal_op <= (d2_upc == ILLEGAL_UPC);
                    end
                    SEQ_JUMP: upc <= uword.target;
                    SEQ_BRZ:  upc <= cond_zero ? uword.target : upc_inc;
                    SEQ_WAIT: begin
                        // A late mem_ready still completes the access on the timeout cycle
                        if (mem_ready) begin
                            upc      <= upc_inc;
                            wait_cnt <= '0;
                        end else if (wait_cnt == WCNT_W'(WAIT_MAX)) begin
                            upc         <= '0;
                            wait_cnt    <= '0;
                            mem_timeout <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WCNT_W'(1);
                        end
                    end
                    SEQ_HALT: halted <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_microseq_ctrl.sv
// tb/tb_microseq_ctrl.sv - directed self-checking bench for microseq_ctrl
module tb_microseq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        cond_zero;
    logic        mem_ready;
    logic        stall;
    logic [4:0]  upc;
    logic [15:0] ctrl_word;
    logic        instr_done;
    logic        illegal_op;
    logic        mem_timeout;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    microseq_ctrl #(.UPC_W(5), .CW_W(16), .WAIT_MAX(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .cond_zero   (cond_zero),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .upc         (upc),
        .ctrl_word   (ctrl_word),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input int e_upc, input int e_done,
                                input int e_ill, input int e_to, input int e_halt);
        cmp({tag, ".upc"},         {27'd0, upc},         32'(e_upc));
        cmp({tag, ".instr_done"},  {31'd0, instr_done},  32'(e_done));
        cmp({tag, ".illegal_op"},  {31'd0, illegal_op},  32'(e_ill));
        cmp({tag, ".mem_timeout"}, {31'd0, mem_timeout}, 32'(e_to));
        cmp({tag, ".halted"},      {31'd0, halted},      32'(e_halt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'h00; cond_zero = 1'b0; mem_ready = 1'b0; stall = 1'b0;
        #7;
        expect_state("reset", 0, 0, 0, 0, 0);
        cmp("reset.ctrl", {16'd0, ctrl_word}, 32'h9410);
        #5 rst = 1'b0;

        // LW path into WAIT, then asynchronous reset mid-WAIT
        opcode = 6'h23;
        step(); expect_state("lw.decode", 1, 0, 0, 0, 0);
        cmp("lw.decode.ctrl", {16'd0, ctrl_word}, 32'h0018);
        step(); expect_state("lw.disp1", 2, 0, 0, 0, 0);
        step(); expect_state("lw.disp2", 3, 0, 0, 0, 0);
        step(); expect_state("lw.wait", 4, 0, 0, 0, 0);
        cmp("lw.wait.ctrl", {16'd0, ctrl_word}, 32'h0300);
        repeat (7) step();
        expect_state("wait7", 4, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 expect_state("async_rst", 0, 0, 0, 0, 0);
        #1 rst = 1'b0;

        // Timeout: 15 held cycles, expiry on the 16th WAIT cycle returns to 0
        step(); step(); step(); step();
        expect_state("to.enter", 4, 0, 0, 0, 0);
        repeat (15) step();
        expect_state("to.held15", 4, 0, 0, 0, 0);
        step(); expect_state("to.fire", 0, 0, 0, 1, 0);
        step(); expect_state("to.after", 1, 0, 0, 0, 0);

        // mem_ready arriving on the would-be timeout cycle wins
        step(); step(); step();
        expect_state("rdy.enter", 4, 0, 0, 0, 0);
        repeat (15) step();
        mem_ready = 1'b1;
        step(); expect_state("rdy.last", 5, 0, 0, 0, 0);
        mem_ready = 1'b0;
        step(); expect_state("rdy.retire", 0, 1, 0, 0, 0);
        step(); expect_state("rdy.fetch", 1, 0, 0, 0, 0);

        // R-type dispatch
        opcode = 6'h00;
        step(); expect_state("rtype.disp", 6, 0, 0, 0, 0);
        cmp("rtype.ctrl", {16'd0, ctrl_word}, 32'h0044);
        step(); expect_state("rtype.wb", 7, 0, 0, 0, 0);
        step(); expect_state("rtype.retire", 0, 1, 0, 0, 0);
        step();

        // BRZ taken
        opcode = 6'h04; cond_zero = 1'b1;
        step(); expect_state("beq.disp", 8, 0, 0, 0, 0);
        step(); expect_state("brz.taken", 12, 0, 0, 0, 0);
        step(); expect_state("brz.retire", 0, 1, 0, 0, 0);
        step();

        // BRZ not taken falls through to 9, whose JUMP goes to 30
        cond_zero = 1'b0;
        step(); step(); expect_state("brz.fall", 9, 0, 0, 0, 0);
        step(); expect_state("jump", 30, 0, 0, 0, 0);

        // Stall holds upc at 30 for three edges
        stall = 1'b1;
        step(); step(); step();
        expect_state("stall3", 30, 0, 0, 0, 0);
        stall = 1'b0;
        step(); expect_state("next30", 31, 0, 0, 0, 0);
        cmp("halt.ctrl", {16'd0, ctrl_word}, 32'h0000);
        step(); expect_state("halt", 31, 0, 0, 0, 1);
        stall = 1'b1; step(); stall = 1'b0; opcode = 6'h23; step();
        expect_state("halt.sticky", 31, 0, 0, 0, 1);

        // Store path and illegal opcode at DISP2
        rst = 1'b1; #2 rst = 1'b0;
        opcode = 6'h2B;
        step(); step(); step();
        expect_state("sw.disp2", 5, 0, 0, 0, 0);
        step(); step(); step();
        opcode = 6'h04;
        step(); expect_state("disp2.illegal", 31, 0, 1, 0, 0);
        step(); expect_state("disp2.halt", 31, 0, 0, 0, 1);

        // Illegal opcode at DISP1
        rst = 1'b1; #2 rst = 1'b0;
        opcode = 6'h3F;
        step(); step(); expect_state("disp1.illegal", 31, 0, 1, 0, 0);
        step(); expect_state("disp1.halt", 31, 0, 0, 0, 1);
        opcode = 6'h00; stall = 1'b1; step(); stall = 1'b0; step();
        expect_state("disp1.sticky", 31, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
